// File: rtl/column_stream_packer_pkg.sv
// rtl/column_stream_packer_pkg.sv - shared types and helpers for the column stream packer
// Holds the column-width resolver, the fill-count type and the output-register state enum.
package column_packer_pkg;

  typedef logic [15:0] fill_cnt_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int resolve_w(input int bit_width, input int out_bit_width);
    return (out_bit_width == -1) ? bit_width : out_bit_width;
  endfunction

endpackage

// File: rtl/column_stream_packer_if.sv
// rtl/column_stream_packer_if.sv - element-in / word-out handshake bundle for the packer
// The flush signal exists only when PACKER_FLUSH_EN is defined.
interface column_stream_packer_if #(
  parameter int BIT_WIDTH     = 4,
  parameter int OUT_BIT_WIDTH = -1,
  parameter int COLS          = 8
);
  localparam int W  = column_packer_pkg::resolve_w(BIT_WIDTH, OUT_BIT_WIDTH);
  localparam int CW = $clog2(COLS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_WIDTH-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [COLS*W-1:0]     out_data;
  logic [CW-1:0]         out_len;
`ifdef PACKER_FLUSH_EN
  logic                  flush;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef PACKER_FLUSH_EN
    input  flush,
`endif
    output in_ready, out_valid, out_data, out_len
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef PACKER_FLUSH_EN
    output flush,
`endif
    input  in_ready, out_valid, out_data, out_len
  );

endinterface

// File: rtl/column_stream_packer_out_reg.sv
// rtl/column_stream_packer_out_reg.sv - one-entry output register with EMPTY/FULL control
// A load while FULL is only taken together with the downstream accept, replacing the word bubble-free.
module packer_out_reg
  import column_packer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len
);

  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_FULL  = FULL;

  logic [0:0] state;
  logic [0:0] state_nx;
  logic       accept;
  logic       take;

  assign out_valid = (state == ST_FULL);
  assign accept    = out_valid && out_ready;
  assign take      = load && (!out_valid || out_ready);

  always_comb begin
    state_nx = state;
    case (state)
      ST_EMPTY: if (take) state_nx = ST_FULL;
      ST_FULL:  if (accept && !take) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_len  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        out_data <= load_data;
        out_len  <= load_len;
      end
    end
  end

endmodule

// File: rtl/column_stream_packer.sv
// rtl/column_stream_packer.sv - gathers COLS elements into one flat word, column 0 in the LSBs
// Optional partial-word flush is enabled by defining PACKER_FLUSH_EN.
module column_stream_packer
  import column_packer_pkg::*;
#(
  parameter int BIT_WIDTH     = 4,
  parameter int OUT_BIT_WIDTH = -1,
  parameter int COLS          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  column_stream_packer_if.slave  bus
);

  localparam int        W    = resolve_w(BIT_WIDTH, OUT_BIT_WIDTH);
  localparam int        CW   = $clog2(COLS + 1);
  localparam fill_cnt_t LAST = fill_cnt_t'(COLS - 1);

  logic                       run;
  fill_cnt_t                  cnt;
  logic [W-1:0]               slot [COLS];
  logic [W-1:0]               in_ext;
  logic [COLS-1:0][W-1:0]     word;
  logic                       stall_last;
  logic                       flush_hold;
  logic                       flush_take;
  logic                       in_beat;
  logic                       last_beat;
  logic                       load;
  logic [CW-1:0]              load_len;

  assign in_ext = W'(bus.in_data);

  // Last slot is refused while a finished word is still waiting downstream.
  assign stall_last = (cnt == LAST) && bus.out_valid && !bus.out_ready;

`ifdef PACKER_FLUSH_EN
  assign flush_hold = bus.flush && (cnt != '0);
  assign flush_take = flush_hold && (!bus.out_valid || bus.out_ready);
  assign load_len   = last_beat ? CW'(COLS) : CW'(cnt);
`else
  assign flush_hold = 1'b0;
  assign flush_take = 1'b0;
  assign load_len   = CW'(COLS);
`endif

  assign bus.in_ready = run && !stall_last && !flush_hold;
  assign in_beat      = bus.in_valid && bus.in_ready;
  assign last_beat    = in_beat && (cnt == LAST);
  assign load         = last_beat || flush_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else begin
      run <= 1'b1;
      if (load)
        cnt <= '0;
      else if (in_beat)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COLS; i++)
        slot[i] <= '0;
    end else begin
      for (int i = 0; i < COLS; i++)
        if (in_beat && (cnt == fill_cnt_t'(i)))
          slot[i] <= in_ext;
    end
  end

  // Slots at or above cnt are stale, so they read as zero; the completing element bypasses its slot.
  for (genvar i = 0; i < COLS; i++) begin : g_col
    localparam fill_cnt_t IDX = fill_cnt_t'(i);
    assign word[i] = (IDX < cnt)                 ? slot[i] :
                     ((IDX == cnt) && in_beat)   ? in_ext  : '0;
  end

  packer_out_reg #(
    .DATA_W (COLS * W),
    .LEN_W  (CW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (word),
    .load_len  (load_len),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_len   (bus.out_len)
  );

endmodule

// File: tb/tb_column_stream_packer.sv
// tb/tb_column_stream_packer.sv - directed and randomized checks of column_stream_packer
// Flush checks are compiled in when PACKER_FLUSH_EN is defined.
module tb_column_stream_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  column_stream_packer_if #(.BIT_WIDTH(4), .OUT_BIT_WIDTH(-1), .COLS(4)) bus ();
  column_stream_packer_if #(.BIT_WIDTH(4), .OUT_BIT_WIDTH(8),  .COLS(4)) bus8 ();

  column_stream_packer #(.BIT_WIDTH(4), .OUT_BIT_WIDTH(-1), .COLS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  column_stream_packer #(.BIT_WIDTH(4), .OUT_BIT_WIDTH(8), .COLS(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 1'b0);
    bus8.in_valid  = 1'b0;
    bus8.in_data   = 4'h0;
    bus8.out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    bus.flush  = 1'b0;
    bus8.flush = 1'b0;
`endif
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_len",   32'(bus.out_len),   32'h0);
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic push_word_1234(input string tag);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 1'b1);
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
      step();
    end
    drive(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    check({tag, "_data"},  32'(bus.out_data),  32'h4321);
    check({tag, "_len"},   32'(bus.out_len),   32'h4);
    step();
  endtask

  logic [3:0]  part [$];
  logic [15:0] held [$];
  logic        v;
  logic        r;
  logic        exp_rdy;
  logic [3:0]  d;
  logic [15:0] w;

  initial begin
    do_reset();

    // basic back-to-back word
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 1'b1);
      @(negedge clk);
      check("t1_in_ready",    32'(bus.in_ready),  32'h1);
      check("t1_early_valid", 32'(bus.out_valid), 32'h0);
      step();
    end
    drive(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_data",  32'(bus.out_data),  32'h4321);
    check("t1_len",   32'(bus.out_len),   32'h4);
    step();
    @(negedge clk);
    check("t1_drained", 32'(bus.out_valid), 32'h0);
    step();

    // stalled output: three more accepted, last slot refused
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 1'b0);
      step();
    end
    for (int k = 5; k <= 7; k++) begin
      drive(1'b1, 4'(k), 1'b0);
      @(negedge clk);
      check("t2_in_ready",   32'(bus.in_ready),  32'h1);
      check("t2_hold_valid", 32'(bus.out_valid), 32'h1);
      check("t2_hold_data",  32'(bus.out_data),  32'h4321);
      step();
    end
    drive(1'b1, 4'h8, 1'b0);
    @(negedge clk);
    check("t2_last_refused", 32'(bus.in_ready), 32'h0);
    step();
    @(negedge clk);
    check("t2_still_data", 32'(bus.out_data), 32'h4321);
    drive(1'b1, 4'h8, 1'b1);
    #1;
    check("t2_ready_comb", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("t2_next_valid", 32'(bus.out_valid), 32'h1);
    check("t2_next_data",  32'(bus.out_data),  32'h8765);
    drive(1'b0, 4'h0, 1'b1);
    step();
    @(negedge clk);
    check("t2_drained", 32'(bus.out_valid), 32'h0);
    step();

    // asynchronous reset with a pending word and a partial word
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 1'b0);
      step();
    end
    drive(1'b1, 4'h9, 1'b0);
    step();
    drive(1'b1, 4'ha, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0);
    @(negedge clk);
    check("t4_pre_valid", 32'(bus.out_valid), 32'h1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_valid", 32'(bus.out_valid), 32'h0);
    check("t4_async_data",  32'(bus.out_data),  32'h0);
    check("t4_async_ready", 32'(bus.in_ready),  32'h0);
    #2 rst_n = 1'b1;
    step();
    step();
    push_word_1234("t4");

    // wider column slots
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus8.in_valid = 1'b1;
      case (k)
        0: bus8.in_data = 4'hf;
        1: bus8.in_data = 4'h0;
        2: bus8.in_data = 4'ha;
        default: bus8.in_data = 4'h5;
      endcase
      step();
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(bus8.out_valid), 32'h1);
    check("t5_data",  32'(bus8.out_data),  32'h050a000f);
    check("t5_len",   32'(bus8.out_len),   32'h4);
    step();

`ifdef PACKER_FLUSH_EN
    drive(1'b1, 4'h5, 1'b1);
    step();
    drive(1'b1, 4'h6, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    check("t6_flush_ready", 32'(bus.in_ready), 32'h0);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(bus.out_valid), 32'h1);
    check("t6_data",  32'(bus.out_data),  32'h0065);
    check("t6_len",   32'(bus.out_len),   32'h2);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("t6_noop_valid", 32'(bus.out_valid), 32'h0);
    step();
    push_word_1234("t6_next");
`endif

    // randomized traffic against a queue-based reference
    do_reset();
    part.delete();
    held.delete();
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      r = (c % 64 < 24) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(v, d, r);
      @(negedge clk);
      exp_rdy = !((part.size() == 3) && (held.size() != 0) && !r);
      check("rnd_in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(held.size() != 0));
      if (held.size() != 0) begin
        check("rnd_out_data", 32'(bus.out_data), 32'(held[0]));
        check("rnd_out_len",  32'(bus.out_len),  32'h4);
        if (r)
          void'(held.pop_front());
      end
      if (v && exp_rdy) begin
        part.push_back(d);
        if (part.size() == 4) begin
          w = '0;
          for (int i = 0; i < 4; i++)
            w = w | (16'(part[i]) << (4 * i));
          held.push_back(w);
          part.delete();
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
